// File: rtl/fmpad_pkg.sv
// Shared sizing helpers for the feature-map padding stage and its position counter.
package fmpad_pkg;

    typedef struct packed {
        int unsigned cf;
        int unsigned out_w;
        int unsigned out_h;
        int unsigned fold_bits;
        int unsigned x_bits;
        int unsigned y_bits;
    } fmpad_dims_t;

    // A counter over n values needs at least one bit even when n is 1.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit channels_ok(input int unsigned num_channels, input int unsigned simd);
        return (simd != 0) && ((num_channels % simd) == 0);
    endfunction

    function automatic fmpad_dims_t fmpad_dims(
        input int unsigned num_channels,
        input int unsigned simd,
        input int unsigned in_h,
        input int unsigned in_w,
        input int unsigned pad_top,
        input int unsigned pad_bottom,
        input int unsigned pad_left,
        input int unsigned pad_right
    );
        fmpad_dims_t d;
        d.cf        = num_channels / simd;
        d.out_w     = in_w + pad_left + pad_right;
        d.out_h     = in_h + pad_top + pad_bottom;
        d.fold_bits = cnt_bits(d.cf);
        d.x_bits    = cnt_bits(d.out_w);
        d.y_bits    = cnt_bits(d.out_h);
        return d;
    endfunction

endpackage

// File: rtl/fmpad_pos_counter.sv
// Fold/X/Y nested position counter for pixel-major, fold-minor streams; flags the
// interior window so a stage knows when a beat comes from its input.
module fmpad_pos_counter
    import fmpad_pkg::*;
#(
    parameter int unsigned CF       = 16,
    parameter int unsigned OUT_W    = 14,
    parameter int unsigned OUT_H    = 14,
    parameter int unsigned INNER_X0 = 1,
    parameter int unsigned INNER_X1 = 13,
    parameter int unsigned INNER_Y0 = 1,
    parameter int unsigned INNER_Y1 = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    output logic interior
);

    localparam int unsigned FOLD_BITS = cnt_bits(CF);
    localparam int unsigned X_BITS    = cnt_bits(OUT_W);
    localparam int unsigned Y_BITS    = cnt_bits(OUT_H);

    logic [FOLD_BITS-1:0] fold;
    logic [X_BITS-1:0]    x;
    logic [Y_BITS-1:0]    y;
    logic                 fold_last;
    logic                 x_last;
    logic                 y_last;
    logic [31:0]          x_w;
    logic [31:0]          y_w;

    assign fold_last = (fold == FOLD_BITS'(CF - 1));
    assign x_last    = (x == X_BITS'(OUT_W - 1));
    assign y_last    = (y == Y_BITS'(OUT_H - 1));

    // Bounds are compared at 32 bits: the exclusive upper edge may not fit the counter width.
    assign x_w      = 32'(x);
    assign y_w      = 32'(y);
    assign interior = (x_w >= INNER_X0) && (x_w < INNER_X1) &&
                      (y_w >= INNER_Y0) && (y_w < INNER_Y1);

    always_ff @(posedge clk) begin
        if (rst) begin
            fold <= '0;
            x    <= '0;
            y    <= '0;
        end else if (advance) begin
            if (fold_last) begin
                fold <= '0;
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else begin
                fold <= fold + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fm_padding_stream.sv
// Streaming zero-padder: wraps each HxWxC frame in pad rows/columns, one fold per beat,
// frames back-to-back. One-beat output register, 1-cycle latency, full throughput.
module fm_padding_stream
    import fmpad_pkg::*;
#(
    parameter int unsigned BIT_WIDTH    = 8,
    parameter int unsigned SIMD         = 1,
    parameter int unsigned NUM_CHANNELS = 16,
    parameter int unsigned IN_H         = 12,
    parameter int unsigned IN_W         = 12,
    parameter int unsigned PAD_TOP      = 1,
    parameter int unsigned PAD_BOTTOM   = 1,
    parameter int unsigned PAD_LEFT     = 1,
    parameter int unsigned PAD_RIGHT    = 1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in0_V_V_TVALID,
    output logic                      in0_V_V_TREADY,
    input  logic [BIT_WIDTH*SIMD-1:0] in0_V_V_TDATA,
    output logic                      out_V_V_TVALID,
    input  logic                      out_V_V_TREADY,
    output logic [BIT_WIDTH*SIMD-1:0] out_V_V_TDATA
);

    localparam fmpad_dims_t DIMS = fmpad_dims(NUM_CHANNELS, SIMD, IN_H, IN_W,
                                              PAD_TOP, PAD_BOTTOM, PAD_LEFT, PAD_RIGHT);

    if (!channels_ok(NUM_CHANNELS, SIMD)) begin : g_bad_fold
        $error("fm_padding_stream: NUM_CHANNELS must be a multiple of SIMD");
    end

    logic                      out_valid;
    logic [BIT_WIDTH*SIMD-1:0] out_data;
    logic                      load;
    logic                      interior;
    logic                      advance;

    fmpad_pos_counter #(
        .CF       (DIMS.cf),
        .OUT_W    (DIMS.out_w),
        .OUT_H    (DIMS.out_h),
        .INNER_X0 (PAD_LEFT),
        .INNER_X1 (PAD_LEFT + IN_W),
        .INNER_Y0 (PAD_TOP),
        .INNER_Y1 (PAD_TOP + IN_H)
    ) u_pos (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .advance  (advance),
        .interior (interior)
    );

    // Handshake: a beat moves on either side only when VALID and READY are both high at the
    // clock edge; the output register refills whenever it is empty or being drained.
    assign load           = !out_valid || out_V_V_TREADY;
    assign in0_V_V_TREADY = !ap_rst && interior && load;
    assign advance        = load && (!interior || in0_V_V_TVALID);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            if (interior) begin
                // With no input the position holds and the register goes empty until data arrives.
                out_valid <= in0_V_V_TVALID;
                if (in0_V_V_TVALID) begin
                    out_data <= in0_V_V_TDATA;
                end
            end else begin
                out_valid <= 1'b1;
                out_data  <= '0;
            end
        end
    end

    assign out_V_V_TVALID = out_valid;
    assign out_V_V_TDATA  = out_data;

endmodule
